// File: rtl/rob_nway_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rob_nway_pkg                                                    |
// | Purpose  : Shared configuration, entry record and tag-match helper for    |
// |            the N-way reorder buffer (rob_nway, rob_retire_sel).           |
// | Contents : N_WAY, N_ROB, TAG_W, XLEN, ROB_IDX_W, CNT_W, LANE_W,           |
// |            rob_entry_t, tag_hit()                                         |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package rob_nway_pkg;

  localparam int N_WAY     = 2;
  localparam int N_ROB     = 32;
  localparam int TAG_W     = 6;
  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = $clog2(N_ROB);
  localparam int CNT_W     = ROB_IDX_W + 1;
  localparam int LANE_W    = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic             branch;
    logic             mispred;
    logic             halt;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] told;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  target;
  } rob_entry_t;

  // Tag 0 is reserved as "no register" and must never match a broadcast.
  function automatic logic tag_hit(input logic [TAG_W-1:0] entry_tag,
                                   input logic [TAG_W-1:0] bus_tag);
    return (entry_tag != '0) && (entry_tag == bus_tag);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_retire_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rob_retire_sel                                                  |
// | Purpose  : Picks which of the N_WAY oldest entries retire this cycle.     |
// |            Retirement is contiguous from lane 0 and stops after a         |
// |            mispredicted branch or a halt.                                 |
// | Ports    : halted      in  no retirement at all once halted              |
// |            valid/done/mispred/halt in  per head-relative lane flags       |
// |            retire      out contiguous retire mask                         |
// |            flush       out a mispredicted branch retires                  |
// |            flush_lane  out lane of that branch                            |
// |            halt_retire out a halt entry retires                           |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rob_retire_sel
  import rob_nway_pkg::*;
(
  input  logic              halted,
  input  logic [N_WAY-1:0]  valid,
  input  logic [N_WAY-1:0]  done,
  input  logic [N_WAY-1:0]  mispred,
  input  logic [N_WAY-1:0]  halt,
  output logic [N_WAY-1:0]  retire,
  output logic              flush,
  output logic [LANE_W-1:0] flush_lane,
  output logic              halt_retire
);

  logic go;

  always_comb begin
    retire      = '0;
    flush       = 1'b0;
    flush_lane  = '0;
    halt_retire = 1'b0;
    go          = !halted;
    for (int k = 0; k < N_WAY; k++) begin
      retire[k] = go && valid[k] && done[k];
      if (retire[k] && mispred[k]) begin
        flush      = 1'b1;
        flush_lane = LANE_W'(k);
      end
      if (retire[k] && halt[k]) begin
        halt_retire = 1'b1;
      end
      // Younger lanes may only follow an ordinary retiring entry.
      go = retire[k] && !mispred[k] && !halt[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rob_nway                                                        |
// | Purpose  : N-way reorder buffer. In-order dispatch of up to N_WAY entries |
// |            per cycle, tag-CAM completion from N_WAY CDB lanes plus the    |
// |            branch unit, in-order retire of up to N_WAY entries per cycle, |
// |            precise flush on a retiring mispredicted branch, stop on halt. |
// | Ports    : clock, reset              clock / synchronous active-high rst  |
// |            dis_*                     dispatch lanes, dis_ready accepts    |
// |            cmp_valid, cmp_tag        completion broadcasts                |
// |            br_*                      branch resolution                    |
// |            ret_*                     retire lanes (contiguous from 0)     |
// |            flush, flush_pc           redirect on retiring mispredict      |
// |            halted                    sticky once a halt retires           |
// |            free_slots                N_ROB - occupancy (registered)       |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rob_nway
  import rob_nway_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_WAY-1:0]        dis_valid,
  input  logic [N_WAY*TAG_W-1:0]  dis_tag,
  input  logic [N_WAY*TAG_W-1:0]  dis_told,
  input  logic [N_WAY*XLEN-1:0]   dis_pc,
  input  logic [N_WAY-1:0]        dis_branch,
  input  logic [N_WAY-1:0]        dis_halt,
  output logic [N_WAY-1:0]        dis_ready,
  input  logic [N_WAY-1:0]        cmp_valid,
  input  logic [N_WAY*TAG_W-1:0]  cmp_tag,
  input  logic                    br_valid,
  input  logic [TAG_W-1:0]        br_tag,
  input  logic                    br_mispred,
  input  logic [XLEN-1:0]         br_target,
  output logic [N_WAY-1:0]        ret_valid,
  output logic [N_WAY*TAG_W-1:0]  ret_tag,
  output logic [N_WAY*TAG_W-1:0]  ret_told,
  output logic [N_WAY*XLEN-1:0]   ret_pc,
  output logic                    flush,
  output logic [XLEN-1:0]         flush_pc,
  output logic                    halted,
  output logic [CNT_W-1:0]        free_slots
);

  rob_entry_t           entries [N_ROB];
  logic [ROB_IDX_W-1:0] head;
  logic [ROB_IDX_W-1:0] tail;
  logic [CNT_W-1:0]     count;

  logic [N_WAY-1:0]     win_valid;
  logic [N_WAY-1:0]     win_done;
  logic [N_WAY-1:0]     win_mispred;
  logic [N_WAY-1:0]     win_halt;
  logic [N_WAY-1:0]     retire;
  logic                 sel_flush;
  logic [LANE_W-1:0]    flush_lane;
  logic                 halt_retire;

  logic                 dis_go;
  logic [CNT_W-1:0]     acc_cnt;
  logic [CNT_W-1:0]     ret_cnt;
  logic [CNT_W-1:0]     count_next;
  logic [N_ROB-1:0]     cmp_hit;
  logic [N_ROB-1:0]     br_hit;

  // Head-relative window feeding the selector and the retire ports.
  for (genvar k = 0; k < N_WAY; k++) begin : g_lane
    logic [ROB_IDX_W-1:0] idx;
    assign idx         = head + ROB_IDX_W'(k);
    assign win_valid[k]   = entries[idx].valid;
    assign win_done[k]    = entries[idx].done;
    assign win_mispred[k] = entries[idx].mispred;
    assign win_halt[k]    = entries[idx].halt;
    assign ret_tag[k*TAG_W +: TAG_W]  = entries[idx].tag;
    assign ret_told[k*TAG_W +: TAG_W] = entries[idx].told;
    assign ret_pc[k*XLEN +: XLEN]     = entries[idx].pc;
  end

  rob_retire_sel u_retire_sel (
    .halted      (halted),
    .valid       (win_valid),
    .done        (win_done),
    .mispred     (win_mispred),
    .halt        (win_halt),
    .retire      (retire),
    .flush       (sel_flush),
    .flush_lane  (flush_lane),
    .halt_retire (halt_retire)
  );

  assign ret_valid = reset ? '0 : retire;
  assign flush     = sel_flush && !reset;
  assign flush_pc  = flush ? entries[head + ROB_IDX_W'(flush_lane)].target : '0;

  // Dispatch acceptance is a prefix: the first refused lane blocks all
  // younger lanes. free_slots is the start-of-cycle capacity, so slots
  // freed by this cycle's retirement are not reused until the next cycle.
  always_comb begin
    dis_ready = '0;
    acc_cnt   = '0;
    dis_go    = !reset && !sel_flush && !halted;
    for (int i = 0; i < N_WAY; i++) begin
      dis_go       = dis_go && dis_valid[i] && (CNT_W'(i) < free_slots);
      dis_ready[i] = dis_go;
      acc_cnt      = acc_cnt + CNT_W'(dis_go);
    end
  end

  always_comb begin
    ret_cnt = '0;
    for (int k = 0; k < N_WAY; k++) begin
      ret_cnt = ret_cnt + CNT_W'(retire[k]);
    end
  end

  assign count_next = count + acc_cnt - ret_cnt;

  // Completion CAM. Only entries already valid are matched, so entries
  // written this cycle can never pick up a same-cycle broadcast.
  always_comb begin
    for (int e = 0; e < N_ROB; e++) begin
      cmp_hit[e] = 1'b0;
      for (int j = 0; j < N_WAY; j++) begin
        if (cmp_valid[j] && tag_hit(entries[e].tag, cmp_tag[j*TAG_W +: TAG_W])) begin
          cmp_hit[e] = 1'b1;
        end
      end
      br_hit[e] = br_valid && tag_hit(entries[e].tag, br_tag);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ROB; i++) begin
        entries[i] <= '0;
      end
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      halted     <= 1'b0;
      free_slots <= CNT_W'(N_ROB);
    end else if (sel_flush) begin
      // Precise flush: everything younger than the branch is discarded,
      // and this cycle's completions and dispatches are dropped.
      for (int i = 0; i < N_ROB; i++) begin
        entries[i].valid <= 1'b0;
      end
      head       <= head + ROB_IDX_W'(ret_cnt);
      tail       <= head + ROB_IDX_W'(ret_cnt);
      count      <= '0;
      halted     <= halted | halt_retire;
      free_slots <= CNT_W'(N_ROB);
    end else begin
      for (int e = 0; e < N_ROB; e++) begin
        if (entries[e].valid) begin
          if (cmp_hit[e]) begin
            entries[e].done <= 1'b1;
          end
          if (br_hit[e]) begin
            entries[e].done    <= 1'b1;
            entries[e].mispred <= br_mispred && entries[e].branch;
            entries[e].target  <= br_target;
          end
        end
      end
      for (int k = 0; k < N_WAY; k++) begin
        if (retire[k]) begin
          entries[head + ROB_IDX_W'(k)].valid <= 1'b0;
        end
      end
      // Dispatch slots are always currently invalid, so they never
      // collide with the retire or completion updates above.
      for (int i = 0; i < N_WAY; i++) begin
        if (dis_ready[i]) begin
          entries[tail + ROB_IDX_W'(i)] <= '{
            valid:   1'b1,
            done:    1'b0,
            branch:  dis_branch[i],
            mispred: 1'b0,
            halt:    dis_halt[i],
            tag:     dis_tag[i*TAG_W +: TAG_W],
            told:    dis_told[i*TAG_W +: TAG_W],
            pc:      dis_pc[i*XLEN +: XLEN],
            target:  '0
          };
        end
      end
      head       <= head + ROB_IDX_W'(ret_cnt);
      tail       <= tail + ROB_IDX_W'(acc_cnt);
      count      <= count_next;
      halted     <= halted | halt_retire;
      free_slots <= CNT_W'(N_ROB) - count_next;
    end
  end

endmodule
`default_nettype wire
